// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Writer side of the instruction-memory interface. A host/debug byte source
// streams a program image over a valid/ready handshake; this block assembles
// 16-bit instruction words, writes them into instruction memory and keeps the
// CPU held in reset until a load with a good checksum has completed.
//
// Stream format (in order):
//   len[15:8], len[7:0]                  -- word count N, excluded from checksum
//   N x { word[15:8], word[7:0] }         -- instruction words
//   chk                                   -- XOR of all 2N data bytes (0x00 if N=0)
//
// Parameters:
//   MEM_DEPTH  number of 16-bit words in instruction memory; maximum legal N
//   BASE_ADDR  word address written for the first loaded instruction
//
// Ports:
//   clk        system clock, everything on the rising edge
//   reset      synchronous active-low reset (0 = reset)
//   start      one-cycle pulse arming a new load (honoured in IDLE/DONE/ERR)
//   in_valid   byte source has in_data available
//   in_data    stream byte
//   in_ready   loader accepts a byte this cycle (registered, state-only)
//   mem_we     one-cycle write strobe per assembled word
//   mem_addr   word address for the write (holds between writes)
//   mem_wdata  instruction word {high byte, low byte} (holds between writes)
//   cpu_hold   1 = keep CPU (PC, register file) in reset
//   done       sticky: load finished with good checksum
//   error      sticky: load rejected (length or checksum)
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StDataHi,
    StDataLo,
    StChk,
    StDone,
    StErr
  } state_e;

  state_e      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [15:0] len_q, len_d;
  logic [15:0] index_q, index_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  hi_q, hi_d;

  logic        xfer;
  logic [31:0] len_full;
  logic [16:0] index_inc;

  // A byte moves only when the source offers it and we advertised readiness.
  assign xfer      = in_valid & in_ready_q;

  // Full length as it would be latched by the low-length byte this cycle,
  // widened so the comparison against MEM_DEPTH cannot overflow.
  assign len_full  = {16'd0, len_q[15:8], in_data};

  // Index after the word being written; 17 bits so index_q = 0xFFFF does not
  // wrap and look smaller than len.
  assign index_inc = {1'b0, index_q} + 17'd1;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    done_d      = done_q;
    error_d     = error_q;
    len_d       = len_q;
    index_d     = index_q;
    csum_d      = csum_q;
    hi_d        = hi_q;

    case (state_q)
      // Idle and both terminal states share the arming behaviour.
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d    = StLenHi;
          cpu_hold_d = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          index_d    = 16'd0;
          csum_d     = 8'd0;
          len_d      = 16'd0;
        end
      end

      StLenHi: begin
        if (xfer) begin
          len_d[15:8] = in_data;
          state_d     = StLenLo;
        end
      end

      StLenLo: begin
        if (xfer) begin
          len_d = len_full[15:0];
          if (len_full > MEM_DEPTH) begin
            state_d = StErr;
            error_d = 1'b1;
          end else if (len_full == 32'd0) begin
            state_d = StChk;
          end else begin
            state_d = StDataHi;
          end
        end
      end

      StDataHi: begin
        if (xfer) begin
          hi_d    = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = StDataLo;
        end
      end

      // The word is complete on the low byte; the write strobe is registered so
      // it appears the cycle after the transfer and the stream never stalls.
      StDataLo: begin
        if (xfer) begin
          csum_d      = csum_q ^ in_data;
          mem_we_d    = 1'b1;
          mem_addr_d  = BASE_ADDR + index_q;
          mem_wdata_d = {hi_q, in_data};
          index_d     = index_inc[15:0];
          if (index_inc < {1'b0, len_q}) begin
            state_d = StDataHi;
          end else begin
            state_d = StChk;
          end
        end
      end

      StChk: begin
        if (xfer) begin
          if (in_data == csum_q) begin
            state_d    = StDone;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = StErr;
            error_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Registered readiness: decoded from the state we are about to enter.
    case (state_d)
      StLenHi, StLenLo, StDataHi, StDataLo, StChk: in_ready_d = 1'b1;
      default:                                     in_ready_d = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register (synchronous active-low reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'd0;
      mem_wdata_q <= 16'd0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      len_q       <= 16'd0;
      index_q     <= 16'd0;
      csum_q      <= 8'd0;
      hi_q        <= 8'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
      len_q       <= len_d;
      index_q     <= index_d;
      csum_q      <= csum_d;
      hi_q        <= hi_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
